// File: rtl/unidad_procesadora_param.sv
// Parametrised processing unit: register file, ALU with V/N/Z/C flags, shifter,
// bus muxes, stored flag register and a bit-serial rotate behind a valid/ready handshake.
module unidad_procesadora_param #(
  parameter int WIDTH = 8,
  parameter int NREG  = 4,
  localparam int AW   = $clog2(NREG),
  localparam int SW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ctrl_valid,
  output logic             ctrl_ready,
  input  logic [AW-1:0]    a_sel,
  input  logic [AW-1:0]    b_sel,
  input  logic [AW-1:0]    d_sel,
  input  logic             we,
  input  logic             mb,
  input  logic [3:0]       alu_sel,
  input  logic [1:0]       sh_sel,
  input  logic             mf,
  input  logic             md,
  input  logic             wf,
  input  logic [WIDTH-1:0] const_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] addr_out,
  output logic [3:0]       flags
);

  typedef enum logic {IDLE, ROT} state_t;

  state_t           state_reg;
  logic             ready_reg;
  logic [WIDTH-1:0] regs [NREG];
  logic [3:0]       flags_reg;

  logic [WIDTH-1:0] bus_a;
  logic [WIDTH-1:0] bus_b;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] logic_out;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH:0]   sum;
  logic             cin;
  logic             is_arith;
  logic             ovf;
  logic [3:0]       alu_flags;

  logic [WIDTH-1:0] sh_out;
  logic [WIDTH-1:0] f_out;
  logic [WIDTH-1:0] result;
  logic [SW-1:0]    rot_amt;
  logic             is_rot;
  logic             accept;

  logic [SW-1:0]    cnt_reg;
  logic [WIDTH-1:0] rot_reg;
  logic [WIDTH-1:0] rot_next;
  logic [AW-1:0]    p_d_reg;
  logic             p_we_reg;
  logic             p_wf_reg;
  logic             p_md_reg;
  logic [WIDTH-1:0] p_data_reg;
  logic [3:0]       p_flags_reg;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             fl_en;
  logic [3:0]       fl_data;
  logic [NREG-1:0]  wr_hit;

  assign bus_a    = regs[a_sel];
  assign bus_b    = mb ? const_in : regs[b_sel];
  assign addr_out = bus_a;
  assign data_out = bus_b;
  assign flags    = flags_reg;
  assign ctrl_ready = ready_reg;

  // Every arithmetic op is A + add_b + cin; logic/pass ops bypass the adder.
  always_comb begin
    add_b     = '0;
    cin       = 1'b0;
    is_arith  = 1'b1;
    logic_out = bus_a;
    case (alu_sel)
      4'b0000, 4'b0111: is_arith = 1'b0;
      4'b0001: cin = 1'b1;
      4'b0010: add_b = bus_b;
      4'b0011: begin
        add_b = bus_b;
        cin   = flags_reg[0];
      end
      4'b0100: add_b = ~bus_b;
      4'b0101: begin
        add_b = ~bus_b;
        cin   = 1'b1;
      end
      4'b0110: add_b = '1;
      4'b1000: begin
        is_arith  = 1'b0;
        logic_out = bus_a & bus_b;
      end
      4'b1001: begin
        is_arith  = 1'b0;
        logic_out = bus_a | bus_b;
      end
      4'b1010: begin
        is_arith  = 1'b0;
        logic_out = bus_a ^ bus_b;
      end
      4'b1011: begin
        is_arith  = 1'b0;
        logic_out = ~bus_a;
      end
      default: begin
        is_arith  = 1'b0;
        logic_out = bus_b;
      end
    endcase
  end

  assign sum     = {1'b0, bus_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, cin};
  assign alu_out = is_arith ? sum[WIDTH-1:0] : logic_out;
  assign ovf     = is_arith & (bus_a[WIDTH-1] == add_b[WIDTH-1])
                            & (sum[WIDTH-1] != bus_a[WIDTH-1]);
  assign alu_flags = {ovf, alu_out[WIDTH-1], (alu_out == '0), is_arith & sum[WIDTH]};

  // A rotate by zero is just a pass, so the shifter only needs the trivial cases.
  always_comb begin
    case (sh_sel)
      2'b01:   sh_out = bus_b >> 1;
      2'b10:   sh_out = bus_b << 1;
      default: sh_out = bus_b;
    endcase
  end

  assign f_out    = mf ? sh_out : alu_out;
  assign result   = md ? data_in : f_out;
  assign rot_amt  = const_in[SW-1:0];
  assign is_rot   = (sh_sel == 2'b11) && mf && (rot_amt != '0);
  assign accept   = ctrl_valid && ready_reg;
  assign rot_next = {rot_reg[0], rot_reg[WIDTH-1:1]};

  // Single write port shared by immediate ops and the deferred rotate writeback.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = d_sel;
    wr_data = result;
    fl_en   = 1'b0;
    fl_data = alu_flags;
    if (state_reg == IDLE) begin
      if (accept && !is_rot) begin
        wr_en = we;
        fl_en = wf;
      end
    end else if (cnt_reg == SW'(1)) begin
      wr_en   = p_we_reg;
      wr_addr = p_d_reg;
      wr_data = p_md_reg ? p_data_reg : rot_next;
      fl_en   = p_wf_reg;
      fl_data = p_flags_reg;
    end
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : gen_wr
    assign wr_hit[gi] = wr_en && (wr_addr == AW'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_hit[i]) regs[i] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      ready_reg   <= 1'b1;
      flags_reg   <= 4'b0000;
      cnt_reg     <= '0;
      rot_reg     <= '0;
      p_d_reg     <= '0;
      p_we_reg    <= 1'b0;
      p_wf_reg    <= 1'b0;
      p_md_reg    <= 1'b0;
      p_data_reg  <= '0;
      p_flags_reg <= 4'b0000;
    end else begin
      if (fl_en) flags_reg <= fl_data;
      case (state_reg)
        IDLE: begin
          if (accept && is_rot) begin
            state_reg   <= ROT;
            ready_reg   <= 1'b0;
            cnt_reg     <= rot_amt;
            rot_reg     <= bus_b;
            p_d_reg     <= d_sel;
            p_we_reg    <= we;
            p_wf_reg    <= wf;
            p_md_reg    <= md;
            p_data_reg  <= data_in;
            p_flags_reg <= alu_flags;
          end
        end
        ROT: begin
          rot_reg <= rot_next;
          cnt_reg <= cnt_reg - SW'(1);
          if (cnt_reg == SW'(1)) begin
            state_reg <= IDLE;
            ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unidad_procesadora_param.sv
// Bench for unidad_procesadora_param: two configurations (8x4 and 16x8) against an
// arithmetic reference model, with directed literal checks followed by random traffic.
module tb_unidad_procesadora_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        valid;
  int          cur;
  logic [2:0]  a_sel, b_sel, d_sel;
  logic        we, mb, mf, md, wf;
  logic [3:0]  alu_sel;
  logic [1:0]  sh_sel;
  logic [15:0] const_in, data_in;

  logic        v0, v1, rdy0, rdy1, rdy_cur;
  logic [7:0]  ao0, do0;
  logic [15:0] ao1, do1;
  logic [3:0]  fl0, fl1, fl_cur;

  assign v0 = valid && (cur == 0);
  assign v1 = valid && (cur == 1);
  assign rdy_cur = (cur == 0) ? rdy0 : rdy1;
  assign fl_cur  = (cur == 0) ? fl0 : fl1;

  unidad_procesadora_param #(.WIDTH(8), .NREG(4)) dut0 (
    .clk(clk), .rst(rst), .ctrl_valid(v0), .ctrl_ready(rdy0),
    .a_sel(a_sel[1:0]), .b_sel(b_sel[1:0]), .d_sel(d_sel[1:0]),
    .we(we), .mb(mb), .alu_sel(alu_sel), .sh_sel(sh_sel), .mf(mf), .md(md), .wf(wf),
    .const_in(const_in[7:0]), .data_in(data_in[7:0]),
    .data_out(do0), .addr_out(ao0), .flags(fl0)
  );

  unidad_procesadora_param #(.WIDTH(16), .NREG(8)) dut1 (
    .clk(clk), .rst(rst), .ctrl_valid(v1), .ctrl_ready(rdy1),
    .a_sel(a_sel), .b_sel(b_sel), .d_sel(d_sel),
    .we(we), .mb(mb), .alu_sel(alu_sel), .sh_sel(sh_sel), .mf(mf), .md(md), .wf(wf),
    .const_in(const_in), .data_in(data_in),
    .data_out(do1), .addr_out(ao1), .flags(fl1)
  );

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model state: register contents, flags, and a pending result with
  // the number of cycles left before it lands.
  logic [15:0] m_regs [2][8];
  logic [3:0]  m_fl   [2];
  int          m_cnt  [2];
  int          m_pd   [2];
  bit          m_pwe  [2];
  bit          m_pwf  [2];
  logic [15:0] m_pval [2];
  logic [3:0]  m_pfl  [2];

  function automatic int wid(input int d);
    return (d == 0) ? 8 : 16;
  endfunction

  function automatic int nreg(input int d);
    return (d == 0) ? 4 : 8;
  endfunction

  // Returns {V,N,Z,C, result}; signed overflow judged by true signed arithmetic.
  function automatic logic [19:0] model_alu(input int w, input longint a, input longint b,
                                            input logic [3:0] op, input bit creg);
    longint mask, half, ob, ci, s, res, sa, so, ss;
    bit arith, v, c;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ob = 0; ci = 0; arith = 1'b1; v = 1'b0; c = 1'b0; res = 0;
    case (op)
      4'd1: ci = 1;
      4'd2: ob = b;
      4'd3: begin ob = b; ci = creg ? 1 : 0; end
      4'd4: ob = (~b) & mask;
      4'd5: begin ob = (~b) & mask; ci = 1; end
      4'd6: ob = mask;
      default: arith = 1'b0;
    endcase
    if (arith) begin
      s   = a + ob + ci;
      res = s & mask;
      c   = ((s >> w) & 1) != 0;
      sa  = (a >= half) ? a - 2 * half : a;
      so  = (ob >= half) ? ob - 2 * half : ob;
      ss  = sa + so + ci;
      v   = (ss >= half) || (ss < -half);
    end else begin
      case (op)
        4'd8:    res = a & b;
        4'd9:    res = a | b;
        4'd10:   res = a ^ b;
        4'd11:   res = (~a) & mask;
        4'd0, 4'd7: res = a;
        default: res = b;
      endcase
    end
    return {v, res >= half, res == 0, c, res[15:0]};
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int w, nr, k;
      longint mask, a, b, shv, fv, val;
      logic [19:0] r;
      w = wid(d);
      nr = nreg(d);
      mask = (longint'(1) << w) - 1;
      if (rst) begin
        for (int i = 0; i < 8; i++) m_regs[d][i] = 16'h0;
        m_fl[d] = 4'h0;
        m_cnt[d] = 0;
      end else if (m_cnt[d] > 0) begin
        m_cnt[d]--;
        if (m_cnt[d] == 0) begin
          if (m_pwe[d]) m_regs[d][m_pd[d]] = m_pval[d];
          if (m_pwf[d]) m_fl[d] = m_pfl[d];
        end
      end else if (valid && cur == d) begin
        a = m_regs[d][int'(a_sel) % nr];
        b = mb ? (longint'(const_in) & mask) : m_regs[d][int'(b_sel) % nr];
        r = model_alu(w, a, b, alu_sel, m_fl[d][0]);
        k = int'(const_in) % w;
        case (sh_sel)
          2'd0: shv = b;
          2'd1: shv = b >> 1;
          2'd2: shv = (b << 1) & mask;
          default: shv = ((b >> k) | (b << (w - k))) & mask;
        endcase
        fv  = mf ? shv : longint'(r[15:0]);
        val = md ? (longint'(data_in) & mask) : fv;
        if (sh_sel == 2'd3 && mf && k > 0) begin
          m_cnt[d]  = k;
          m_pd[d]   = int'(d_sel) % nr;
          m_pwe[d]  = we;
          m_pwf[d]  = wf;
          m_pval[d] = val[15:0];
          m_pfl[d]  = r[19:16];
        end else begin
          if (we) m_regs[d][int'(d_sel) % nr] = val[15:0];
          if (wf) m_fl[d] = r[19:16];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("ready0", {15'h0, rdy0}, {15'h0, m_cnt[0] == 0});
      chk("addr0",  {8'h0, ao0}, m_regs[0][a_sel[1:0]]);
      chk("data0",  {8'h0, do0}, mb ? (const_in & 16'h00FF) : m_regs[0][b_sel[1:0]]);
      chk("flags0", {12'h0, fl0}, {12'h0, m_fl[0]});
      chk("ready1", {15'h0, rdy1}, {15'h0, m_cnt[1] == 0});
      chk("addr1",  ao1, m_regs[1][a_sel]);
      chk("data1",  do1, mb ? const_in : m_regs[1][b_sel]);
      chk("flags1", {12'h0, fl1}, {12'h0, m_fl[1]});
    end
  end

  task automatic issue(input int a, input int b, input int d, input bit w_e, input bit m_b,
                       input logic [3:0] alu, input logic [1:0] sh, input bit m_f,
                       input bit m_d, input bit w_f, input logic [15:0] k,
                       input logic [15:0] dat);
    int n = 0;
    while (!rdy_cur && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    chk("issue_ready", {15'h0, rdy_cur}, 16'h1);
    a_sel = 3'(a); b_sel = 3'(b); d_sel = 3'(d);
    we = w_e; mb = m_b; alu_sel = alu; sh_sel = sh;
    mf = m_f; md = m_d; wf = w_f; const_in = k; data_in = dat;
    valid = 1'b1;
    @(posedge clk); #2;
    valid = 1'b0;
  endtask

  task automatic load(input int d, input logic [15:0] v);
    issue(0, 0, d, 1'b1, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0, v);
  endtask

  task automatic rd(input int r, output logic [15:0] v);
    a_sel = 3'(r);
    #1;
    v = (cur == 0) ? {8'h0, ao0} : ao1;
  endtask

  // Counts busy cycles and throws a stray write request at the unit while it is busy.
  task automatic count_busy(output int n);
    n = 0;
    while (!rdy_cur && n < 40) begin
      if (n == 0) begin
        d_sel = 3'd1; md = 1'b1; data_in = 16'hEEEE; we = 1'b1;
        sh_sel = 2'd0; mf = 1'b0; wf = 1'b1; alu_sel = 4'b1011;
        valid = 1'b1;
      end
      @(posedge clk); #2;
      valid = 1'b0;
      n++;
    end
  endtask

  task automatic abort_rot();
    logic [15:0] v;
    issue(2, 1, 2, 1'b1, 1'b0, 4'b1011, 2'b11, 1'b1, 1'b0, 1'b1, 16'h0005, 16'h0);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    chk("abort_ready", {15'h0, rdy_cur}, 16'h1);
    chk("abort_flags", {12'h0, fl_cur}, 16'h0);
    repeat (8) @(posedge clk);
    #2;
    rd(2, v);
    chk("abort_dst", v, 16'h0);
    chk("abort_flags_late", {12'h0, fl_cur}, 16'h0);
  endtask

  initial begin
    logic [15:0] v;
    int n;
    rst = 1'b1; valid = 1'b0; cur = 0;
    a_sel = 0; b_sel = 0; d_sel = 0; we = 0; mb = 0; mf = 0; md = 0; wf = 0;
    alu_sel = 0; sh_sel = 0; const_in = 0; data_in = 0;
    repeat (2) @(posedge clk);
    #2;
    armed = 1'b1;
    rst = 1'b0;
    chk("reset_ready", {15'h0, rdy0}, 16'h1);
    chk("reset_flags", {12'h0, fl0}, 16'h0);

    load(2, 16'h00A5);
    rd(2, v);
    chk("load_r2", v, 16'h00A5);
    chk("load_flags", {12'h0, fl0}, 16'h0);

    load(0, 16'h007F); load(1, 16'h0001);
    issue(0, 1, 3, 1'b1, 1'b0, 4'b0010, 2'd0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    rd(3, v);
    chk("ovf_sum", v, 16'h0080);
    chk("ovf_flags", {12'h0, fl0}, 16'h000C);

    load(0, 16'h00FF);
    issue(0, 1, 2, 1'b1, 1'b0, 4'b0010, 2'd0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    rd(2, v);
    chk("carry_sum", v, 16'h0000);
    chk("carry_flags", {12'h0, fl0}, 16'h0003);
    load(0, 16'h0010); load(1, 16'h0020);
    issue(0, 1, 3, 1'b1, 1'b0, 4'b0011, 2'd0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    rd(3, v);
    chk("adc_sum", v, 16'h0031);
    chk("adc_flags", {12'h0, fl0}, 16'h0000);

    load(1, 16'h0081);
    issue(0, 1, 0, 1'b1, 1'b0, 4'b0000, 2'b11, 1'b1, 1'b0, 1'b0, 16'h0003, 16'h0);
    count_busy(n);
    chk("rot_busy", 16'(n), 16'd3);
    rd(0, v);
    chk("rot_r0", v, 16'h0030);
    rd(1, v);
    chk("rot_stray_ignored", v, 16'h0081);

    issue(0, 1, 0, 1'b1, 1'b0, 4'b0000, 2'b11, 1'b1, 1'b0, 1'b0, 16'h0008, 16'h0);
    chk("rot0_ready", {15'h0, rdy0}, 16'h1);
    rd(0, v);
    chk("rot0_r0", v, 16'h0081);

    issue(2, 0, 0, 1'b0, 1'b0, 4'b1011, 2'd0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    chk("not_flags", {12'h0, fl0}, 16'h0004);
    abort_rot();

    cur = 1;
    load(5, 16'h8001);
    issue(0, 5, 6, 1'b1, 1'b0, 4'b0000, 2'b11, 1'b1, 1'b0, 1'b0, 16'h0004, 16'h0);
    count_busy(n);
    chk("rot16_busy", 16'(n), 16'd4);
    rd(6, v);
    chk("rot16_r6", v, 16'h1800);
    load(0, 16'h7FFF); load(1, 16'h0001);
    issue(0, 1, 3, 1'b1, 1'b0, 4'b0010, 2'd0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    rd(3, v);
    chk("ovf16_sum", v, 16'h8000);
    chk("ovf16_flags", {12'h0, fl1}, 16'h000C);
    abort_rot();

    repeat (3000) begin
      @(posedge clk); #2;
      cur      = int'($urandom_range(0, 1));
      rst      = ($urandom_range(0, 99) == 0);
      valid    = ($urandom_range(0, 3) != 0);
      a_sel    = 3'($urandom_range(0, 7));
      b_sel    = 3'($urandom_range(0, 7));
      d_sel    = 3'($urandom_range(0, 7));
      we       = 1'($urandom_range(0, 1));
      mb       = 1'($urandom_range(0, 1));
      mf       = 1'($urandom_range(0, 1));
      md       = ($urandom_range(0, 3) == 0);
      wf       = 1'($urandom_range(0, 1));
      alu_sel  = 4'($urandom_range(0, 15));
      sh_sel   = 2'($urandom_range(0, 3));
      const_in = 16'($urandom);
      data_in  = 16'($urandom);
    end
    @(posedge clk); #2;
    valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    armed = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/unidad_procesadora_param.md
Name: unidad_procesadora_param

Overview:
Parametrised successor to the 4-bit processing unit: NREG x WIDTH register file, ALU with V/N/Z/C flags, shifter, and the MB/MF/MD bus muxes. Adds a registered flag set with its own write enable, an add-with-carry operation using the stored carry, and a multi-cycle rotate. Control is accepted through a valid/ready handshake so a sequencer can stall on long operations. Sits between the control sequencer and the memory/IO interface.

Parameters:
WIDTH, 8, datapath and register width (>=4)
NREG, 4, number of registers (power of two, >=2)
AW, $clog2(NREG), register address width (derived, do not override)
SW, $clog2(WIDTH), rotate-amount width (derived)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
ctrl_valid  in  1  control word present
ctrl_ready  out  1  unit can accept a control word this cycle
a_sel  in  AW  register A address
b_sel  in  AW  register B address
d_sel  in  AW  destination register address
we  in  1  write result to d_sel
mb  in  1  0: bus B = reg B, 1: bus B = const_in
alu_sel  in  4  ALU function
sh_sel  in  2  shifter function
mf  in  1  0: F = ALU out, 1: F = shifter out
md  in  1  0: result = F, 1: result = data_in
wf  in  1  1: update flag register with this op's ALU flags
const_in  in  WIDTH  constant operand
data_in  in  WIDTH  external data
data_out  out  WIDTH  bus B (combinational: reg[b_sel] or const_in per mb)
addr_out  out  WIDTH  bus A (combinational: reg[a_sel])
flags  out  4  registered {V,N,Z,C}

Behaviour:
- Reset (rst=1 at edge): all registers 0, flags 4'b0000, FSM to IDLE, ctrl_ready=1 in following cycle.
- Accept = ctrl_valid & ctrl_ready at a rising edge; otherwise no state changes.
- ALU (A = bus A, B = bus B, WIDTH+1-bit internal sum): 0000 A; 0001 A+1; 0010 A+B; 0011 A+B+C_reg; 0100 A+~B; 0101 A-B (A+~B+1); 0110 A-1; 0111 A; 1000 A&B; 1001 A|B; 1010 A^B; 1011 ~A; 1100-1111 B.
- Flags: C = carry out of the WIDTH-bit add (0 for logic/pass ops); V = signed overflow of the add (0 for logic/pass); N = ALU out MSB; Z = (ALU out == 0). Always taken from ALU out, not from F.
- Shifter operates on bus B: 00 pass; 01 logical shift right 1; 10 logical shift left 1; 11 rotate right by B-operand-independent amount const_in[SW-1:0] (multi-cycle).
- Single-cycle ops (sh_sel!=11, or sh_sel==11 with amount 0, or mf==0): on the accept edge reg[d_sel] <= result if we; flags <= ALU flags if wf. ctrl_ready stays 1.
- Rotate op (sh_sel==11, mf==1, amount k>0): FSM IDLE->ROT on accept; operands, d_sel, we, wf, md, ALU flags and k latched; ctrl_ready=0. One bit rotated per cycle; after k cycles in ROT, write/flag update occurs on the edge that returns to IDLE. Total: accept edge + k edges; ready reasserts the cycle after the write.
- md==1 during rotate: data_in sampled at accept, write still delayed to completion.
- Register writes visible on addr_out/data_out in the cycle after the write edge; same-register read/write in one op reads old value.
- rst during ROT: abort, no write, no flag update, all state reset.
- ctrl_valid ignored while ctrl_ready=0; inputs may change freely during ROT.
- wf=0: flags hold regardless of op.

Test Plan:
- Reset then load: md=1, data_in=8'hA5, d_sel=2, we=1 -> next cycle a_sel=2 gives addr_out=8'hA5; flags=0000.
- Add overflow: R0=8'h7F, R1=8'h01, alu 0010, wf=1, d_sel=3 -> R3=8'h80, flags V=1 N=1 Z=0 C=0.
- Carry chain: R0=8'hFF+R1=8'h01 wf=1 (R2=00, C=1, Z=1), then 0011 on R0=8'h10,R1=8'h20 -> R3=8'h31.
- Rotate: R1=8'h81, mb=0, sh_sel=11, mf=1, const_in=3, d_sel=0 -> ctrl_ready low exactly 3 cycles, R0=8'h30 after completion; valid pulses during busy ignored.
- Rotate amount 0 -> completes single-cycle, R0=R1, ctrl_ready never drops.
- rst asserted mid-rotate -> destination stays 0, flags 0000, ctrl_ready=1 next cycle; repeat with WIDTH=16, NREG=8.
